// File: rtl/mc_pkg.sv
// mc_pkg: shared state, ALU, opcode/funct and select encodings for the multicycle controller
package mc_pkg;
   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
      S_MEM_WR, S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP
   } state_t;
   localparam logic [4:0] ALU_ADD = 5'd0;
   localparam logic [4:0] ALU_SUB = 5'd1;
   localparam logic [4:0] ALU_AND = 5'd2;
   localparam logic [4:0] ALU_OR  = 5'd3;
   localparam logic [4:0] ALU_SLT = 5'd4;
   localparam logic [4:0] ALU_LUI = 5'd5;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] DST_RT = 2'b00;
   localparam logic [1:0] DST_RD = 2'b01;
   localparam logic [1:0] D2R_ALU = 2'b00;
   localparam logic [1:0] D2R_MEM = 2'b01;
   localparam logic [1:0] PC_INC = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;
   function automatic logic is_mem(input state_t s);
      return s == S_MEM_RD || s == S_MEM_WR;
   endfunction
endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: combinational op/funct to ALUCtr mapping with funct legality
module mc_alu_dec
   import mc_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output logic [4:0] alu_ctr,
   output logic       funct_ok
);
   always_comb begin
      alu_ctr  = ALU_ADD;
      funct_ok = 1'b1;
      case (op)
         OP_RTYPE:
            case (funct)
               FN_ADDU: alu_ctr = ALU_ADD;
               FN_SUBU: alu_ctr = ALU_SUB;
               FN_AND:  alu_ctr = ALU_AND;
               FN_OR:   alu_ctr = ALU_OR;
               FN_SLT:  alu_ctr = ALU_SLT;
               default: funct_ok = 1'b0;
            endcase
         OP_ORI:  alu_ctr = ALU_OR;
         OP_LUI:  alu_ctr = ALU_LUI;
         OP_BEQ:  alu_ctr = ALU_SUB;
         default: alu_ctr = ALU_ADD;
      endcase
   end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS-subset control FSM with bounded memory wait and illegal detection
module mc_ctrl
   import mc_pkg::*;
#(
   parameter int WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       ExtOp,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [4:0] ALUCtr,
   output logic [1:0] RegDst,
   output logic [1:0] Data_to_Reg_sel,
   output logic [1:0] PC_sel,
   output logic       instr_done,
   output logic       illegal,
   output logic [3:0] state
);
   localparam int CW = $clog2(WAIT_MAX + 1);
   state_t cur, nxt;
   logic [CW-1:0] cnt;
   logic [4:0] dec_alu;
   logic funct_ok, op_known, dec_bad, at_max, timeout;
   mc_alu_dec u_dec (.op(op), .funct(funct), .alu_ctr(dec_alu), .funct_ok(funct_ok));
   assign op_known = op inside {OP_RTYPE, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J};
   assign dec_bad  = !op_known || (op == OP_RTYPE && !funct_ok);
   assign at_max   = cnt == CW'(WAIT_MAX);
   // ready in the last allowed cycle wins over timeout
   assign timeout  = is_mem(cur) && !mem_ready && at_max;
   assign state    = cur;
   always_ff @(posedge clk) begin
      if (reset) begin
         cur <= S_FETCH;
         cnt <= '0;
      end else begin
         cur <= nxt;
         cnt <= (is_mem(cur) && nxt == cur) ? cnt + 1'b1 : '0;
      end
   end
   always_comb begin
      nxt = S_FETCH;
      case (cur)
         S_FETCH:    nxt = S_DECODE;
         S_DECODE:   nxt = dec_bad ? S_FETCH :
                           op == OP_RTYPE ? S_EXEC_R :
                           (op == OP_ORI || op == OP_LUI) ? S_EXEC_I :
                           (op == OP_LW || op == OP_SW) ? S_MEM_ADDR :
                           op == OP_BEQ ? S_BRANCH : S_JUMP;
         S_EXEC_R:   nxt = S_WB_R;
         S_EXEC_I:   nxt = S_WB_I;
         S_MEM_ADDR: nxt = op == OP_LW ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   nxt = mem_ready ? S_WB_MEM : at_max ? S_FETCH : S_MEM_RD;
         S_MEM_WR:   nxt = (mem_ready || at_max) ? S_FETCH : S_MEM_WR;
         default:    nxt = S_FETCH;
      endcase
   end
   always_comb begin
      PCWrite         = 1'b0;
      IRWrite         = 1'b0;
      RegWrite        = 1'b0;
      MemRead         = 1'b0;
      MemWrite        = 1'b0;
      ExtOp           = 1'b0;
      ALUSrcA         = 1'b0;
      ALUSrcB         = SRCB_REG;
      ALUCtr          = ALU_ADD;
      RegDst          = DST_RT;
      Data_to_Reg_sel = D2R_ALU;
      PC_sel          = PC_INC;
      instr_done      = 1'b0;
      illegal         = 1'b0;
      if (!reset) begin
         case (cur)
            S_FETCH: begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               ALUSrcB = SRCB_FOUR;
            end
            S_DECODE: illegal = dec_bad;
            S_EXEC_R: begin
               ALUSrcA = 1'b1;
               ALUCtr  = dec_alu;
            end
            S_EXEC_I: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
               ALUCtr  = dec_alu;
            end
            S_MEM_ADDR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
               ExtOp   = 1'b1;
            end
            S_MEM_RD: begin
               MemRead = !timeout;
               illegal = timeout;
            end
            S_MEM_WR: begin
               MemWrite   = !timeout;
               illegal    = timeout;
               instr_done = mem_ready;
            end
            S_WB_R: begin
               RegWrite   = 1'b1;
               RegDst     = DST_RD;
               instr_done = 1'b1;
            end
            S_WB_I: begin
               RegWrite   = 1'b1;
               instr_done = 1'b1;
            end
            S_WB_MEM: begin
               RegWrite        = 1'b1;
               Data_to_Reg_sel = D2R_MEM;
               instr_done      = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA    = 1'b1;
               ALUCtr     = ALU_SUB;
               PC_sel     = PC_BR;
               PCWrite    = zero;
               ExtOp      = 1'b1;
               instr_done = 1'b1;
            end
            S_JUMP: begin
               PCWrite    = 1'b1;
               PC_sel     = PC_JMP;
               instr_done = 1'b1;
            end
            default: illegal = 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed and random instruction traces checked cycle by cycle against a trace model
module tb_mc_ctrl;
   import mc_pkg::*;
   localparam int WM = 15;
   logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
   logic [5:0] op = '0, funct = '0;
   logic PCWrite, IRWrite, RegWrite, MemRead, MemWrite, ExtOp, ALUSrcA, instr_done, illegal;
   logic [1:0] ALUSrcB, RegDst, Data_to_Reg_sel, PC_sel;
   logic [4:0] ALUCtr;
   logic [3:0] state;
   mc_ctrl #(.WAIT_MAX(WM)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemRead(MemRead),
      .MemWrite(MemWrite), .ExtOp(ExtOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUCtr(ALUCtr), .RegDst(RegDst), .Data_to_Reg_sel(Data_to_Reg_sel), .PC_sel(PC_sel),
      .instr_done(instr_done), .illegal(illegal), .state(state)
   );
   always #5 clk = ~clk;
   typedef struct packed {
      logic [3:0] st;
      logic pcw, irw, rw, mr, mw, ext, srca;
      logic [1:0] srcb;
      logic [4:0] alu;
      logic [1:0] rd, d2r, pcs;
      logic done, ill;
   } obs_t;
   typedef struct packed {
      logic rst;
      logic rdy;
      obs_t exp;
   } step_t;
   obs_t obs;
   assign obs = {state, PCWrite, IRWrite, RegWrite, MemRead, MemWrite, ExtOp, ALUSrcA, ALUSrcB,
                 ALUCtr, RegDst, Data_to_Reg_sel, PC_sel, instr_done, illegal};
   step_t q[$];
   int checks = 0, errs = 0;
   string tag;
   function automatic obs_t blank(input state_t s);
      obs_t o = '0;
      o.st = s;
      return o;
   endfunction
   function automatic void push(input obs_t o, input logic rdy = 1'b0, input logic rst = 1'b0);
      step_t s;
      s.rst = rst;
      s.rdy = rdy;
      s.exp = o;
      q.push_back(s);
   endfunction
   // expected per-cycle trace of one instruction, with the mem_ready value to drive each cycle
   function automatic void model(input logic [5:0] o, input logic [5:0] f, input logic z, input int waits);
      obs_t e;
      logic [4:0] falu = 5'd0;
      bit fok = 1'b1;
      bit is_r = o == 6'b000000, is_i = o == 6'b001101 || o == 6'b001111;
      bit is_lw = o == 6'b100011, is_sw = o == 6'b101011;
      bit is_b = o == 6'b000100, is_j = o == 6'b000010;
      bit legal;
      case (f)
         6'b100001: falu = 5'd0;
         6'b100011: falu = 5'd1;
         6'b100100: falu = 5'd2;
         6'b100101: falu = 5'd3;
         6'b101010: falu = 5'd4;
         default:   fok = 1'b0;
      endcase
      legal = (is_r && fok) || is_i || is_lw || is_sw || is_b || is_j;
      e = blank(S_FETCH); e.irw = 1; e.pcw = 1; e.srcb = 2'b01; push(e);
      e = blank(S_DECODE); e.ill = !legal; push(e);
      if (!legal) return;
      if (is_r) begin
         e = blank(S_EXEC_R); e.srca = 1; e.alu = falu; push(e);
         e = blank(S_WB_R); e.rw = 1; e.rd = 2'b01; e.done = 1; push(e);
      end else if (is_i) begin
         e = blank(S_EXEC_I); e.srca = 1; e.srcb = 2'b10; e.alu = o == 6'b001101 ? 5'd3 : 5'd5; push(e);
         e = blank(S_WB_I); e.rw = 1; e.done = 1; push(e);
      end else if (is_lw || is_sw) begin
         e = blank(S_MEM_ADDR); e.srca = 1; e.srcb = 2'b10; e.ext = 1; push(e);
         for (int i = 0; i <= WM; i++) begin
            e = blank(is_lw ? S_MEM_RD : S_MEM_WR);
            if (i >= waits) begin
               e.mr = is_lw; e.mw = is_sw; e.done = is_sw; push(e, 1'b1);
               break;
            end else if (i == WM) begin
               e.ill = 1; push(e);
               return;
            end
            e.mr = is_lw; e.mw = is_sw; push(e);
         end
         if (is_lw) begin
            e = blank(S_WB_MEM); e.rw = 1; e.d2r = 2'b01; e.done = 1; push(e);
         end
      end else if (is_b) begin
         e = blank(S_BRANCH); e.srca = 1; e.alu = 5'd1; e.pcs = 2'b01; e.pcw = z; e.ext = 1; e.done = 1; push(e);
      end else begin
         e = blank(S_JUMP); e.pcw = 1; e.pcs = 2'b10; e.done = 1; push(e);
      end
   endfunction
   task automatic run();
      step_t s;
      while (q.size() > 0) begin
         s = q.pop_front();
         reset = s.rst;
         mem_ready = s.rdy;
         @(negedge clk);
         checks++;
         assert (obs === s.exp) else begin
            errs++;
            $error("FAIL %s step%0d: got %h want %h", tag, checks, obs, s.exp);
         end
         @(posedge clk);
         #1;
      end
   endtask
   task automatic instr(input logic [5:0] o, input logic [5:0] f, input logic z, input int w, input string t);
      op = o; funct = f; zero = z; tag = t;
      model(o, f, z, w);
      run();
   endtask
   initial begin
      logic [5:0] ops[8] = '{6'b000000, 6'b001101, 6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b110011};
      logic [5:0] fns[6] = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
      repeat (2) @(posedge clk);
      #1;
      tag = "reset";
      push(blank(S_FETCH), 1'b0, 1'b1);
      run();
      instr(6'b000000, 6'b100001, 1'b0, 0, "addu");
      instr(6'b100011, 6'b000000, 1'b0, 2, "lw_wait2");
      instr(6'b000100, 6'b000000, 1'b1, 0, "beq_taken");
      instr(6'b000100, 6'b000000, 1'b0, 0, "beq_not");
      instr(6'b101011, 6'b000000, 1'b0, WM + 5, "sw_timeout");
      instr(6'b101011, 6'b000000, 1'b0, WM, "sw_ready_at_max");
      instr(6'b100011, 6'b000000, 1'b0, WM + 1, "lw_timeout");
      instr(6'b111111, 6'b000000, 1'b0, 0, "op_illegal");
      instr(6'b000000, 6'b000000, 1'b0, 0, "funct_illegal");
      instr(6'b001111, 6'b000000, 1'b0, 0, "lui");
      op = 6'b101011; funct = '0; zero = 1'b0; tag = "sw_reset";
      model(6'b101011, 6'b000000, 1'b0, WM + 5);
      while (q.size() > 4) void'(q.pop_back());
      push(blank(S_MEM_WR), 1'b0, 1'b1);
      run();
      instr(6'b000010, 6'b000000, 1'b0, 0, "j_after_reset");
      for (int n = 0; n < 60; n++) begin
         logic [5:0] o = ops[$urandom_range(0, 7)];
         logic [5:0] f = fns[$urandom_range(0, 5)];
         if (o == 6'b110011) o = 6'($urandom_range(0, 63));
         instr(o, f, 1'($urandom_range(0, 1)), int'($urandom_range(0, WM + 2)), "random");
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
